// File: rtl/dense1_deserial.sv
// dense1_deserial
//   Collects a frame of N_WORDS serial signed beats. Each accepted beat is
//   summed with its bias, saturated to DATA_W bits and written to a shadow
//   buffer. When the last beat arrives, the whole buffer is published on
//   dense_out in one step. Malformed frames are reported on frame_err and
//   never touch dense_out.
//
// Ports
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   frame_start  in   one-cycle pulse arming a new frame
//   frame_end    in   high with the final valid beat of a frame
//   valid        in   qualifies din/bias for one beat
//   din          in   signed data word (DATA_W)
//   bias         in   signed bias word, aligned with din (DATA_W)
//   dense_out    out  result vector, word k at [k*DATA_W +: DATA_W]
//   done         out  one-cycle pulse, dense_out holds the new frame
//   busy         out  high while a frame is being received
//   frame_err    out  one-cycle pulse after a malformed frame
module dense1_deserial #(
  parameter int N_WORDS = 120,
  parameter int DATA_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_start,
  input  logic                        frame_end,
  input  logic                        valid,
  input  logic signed [DATA_W-1:0]    din,
  input  logic signed [DATA_W-1:0]    bias,
  output logic [N_WORDS*DATA_W-1:0]   dense_out,
  output logic                        done,
  output logic                        busy,
  output logic                        frame_err
);

  localparam int CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [CNT_W-1:0]            r_cnt;
  logic [CNT_W-1:0]            w_cnt_nxt;
  logic                        w_wr;
  logic                        w_err;
  logic                        w_done;
  logic signed [DATA_W-1:0]    w_sum;
  logic signed [DATA_W-1:0]    r_shadow [N_WORDS];
  logic [N_WORDS*DATA_W-1:0]   r_dense;
  logic [N_WORDS*DATA_W-1:0]   w_load;
  logic                        r_done;
  logic                        r_err;

  // One extra bit of headroom; overflow shows up as a mismatch of the two
  // top bits of the wide sum.
  function automatic logic signed [DATA_W-1:0] sat_add(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1])
      return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      return s[DATA_W-1:0];
  endfunction

  assign w_sum = sat_add(din, bias);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr        = 1'b0;
    w_err       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_start) begin
          w_state_nxt = RECV;
          w_cnt_nxt   = '0;
        end
      end
      RECV: begin
        // A restart wins over everything else in the cycle; its beat is dropped.
        if (frame_start) begin
          w_err     = 1'b1;
          w_cnt_nxt = '0;
        end else if (valid) begin
          w_wr = 1'b1;
          if (r_cnt == LAST) begin
            if (frame_end) begin
              w_done      = 1'b1;
              w_state_nxt = DONE;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = IDLE;
            end
          end else if (frame_end) begin
            w_err       = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else if (frame_end) begin
          w_err       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      DONE: begin
        if (frame_start) begin
          w_state_nxt = RECV;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The final beat is merged straight into the published vector so that
  // dense_out and done appear together one cycle after that beat.
  always_comb begin
    w_load = '0;
    for (int k = 0; k < N_WORDS; k++) begin
      w_load[k*DATA_W +: DATA_W] = (k == N_WORDS - 1) ? w_sum : r_shadow[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_WORDS; k++) r_shadow[k] <= '0;
    end else if (w_wr) begin
      r_shadow[r_cnt] <= w_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dense <= '0;
    end else if (w_done) begin
      r_dense <= w_load;
    end
  end

  assign dense_out = r_dense;
  assign done      = r_done;
  assign frame_err = r_err;
  assign busy      = (r_state == RECV);

endmodule
